// File: rtl/barcode_pkg.sv
// Shared types and constants for the SPI sample reader.
package barcode_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_rd_state_t;

  localparam int SAMPLE_W = 32;

endpackage

// File: rtl/spi_sample_reader_sync_edge.sv
// Two-flop synchroniser for an asynchronous flag, with rising-edge detect
// taken between the second stage and its delayed copy.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic stage1;
  logic stage2;
  logic stage2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1   <= 1'b0;
      stage2   <= 1'b0;
      stage2_d <= 1'b0;
    end else begin
      stage1   <= async_in;
      stage2   <= stage1;
      stage2_d <= stage2;
    end
  end

  assign rise = stage2 & ~stage2_d;

endmodule

// File: rtl/spi_sample_reader.sv
// SPI initiator reading one WIDTH-bit word per frame, MSB first, sampling sdi
// on each rising sck and presenting the word with a one-cycle valid pulse.
module spi_sample_reader
  import barcode_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int CLK_DIV  = 4,
  parameter int CE_SETUP = 2,
  parameter int AUTO     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done_in,
  input  logic             clear_overrun,
  input  logic             sdi,
  output logic             sck,
  output logic             ce,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CE_SETUP + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);

  spi_rd_state_t    state;
  spi_rd_state_t    next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             done_rise;
  logic             trigger;
  logic             div_tc;
  logic             gap_done;
  logic             last_fall;
  logic             ce_d;
  logic             busy_d;

  sync_edge u_done_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (done_in),
    .rise     (done_rise)
  );

  assign trigger   = start | ((AUTO != 0) && done_rise);
  assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign gap_done  = (gap_cnt == GAP_W'(CE_SETUP - 1));
  // The frame ends on the falling toggle that follows the WIDTH-th rising edge.
  assign last_fall = (state == SHIFT) && div_tc && sck && (bit_cnt == BIT_W'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (trigger)   next_state = SETUP;
      SETUP:   if (gap_done)  next_state = SHIFT;
      SHIFT:   if (last_fall) next_state = HOLD;
      HOLD:    if (gap_done)  next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    ce_d   = (next_state == SETUP) || (next_state == SHIFT);
    busy_d = (next_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
    end else begin
      if ((state == SETUP || state == HOLD) && !gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                                gap_cnt <= '0;
      if (state == SHIFT) begin
        div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
        if (div_tc) begin
          sck <= ~sck;
          // sdi is taken in the same clk that raises sck; the responder moves on the fall.
          if (!sck) begin
            shreg   <= {shreg[WIDTH-2:0], sdi};
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sck     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce           <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      overrun      <= 1'b0;
    end else begin
      ce           <= ce_d;
      busy         <= busy_d;
      sample_valid <= last_fall;
      if (last_fall) sample_out <= shreg;
      if (trigger && state != IDLE) overrun <= 1'b1;
      else if (clear_overrun)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_sample_reader.sv
// Scoreboard bench for spi_sample_reader with a shift-on-falling-sck responder model.
module tb_spi_sample_reader;

  localparam int W         = 32;
  localparam int DIV       = 2;
  localparam int GAP       = 2;
  localparam int FRAME_LAT = GAP + 2 * W * DIV;

  logic         clk = 1'b0;
  logic         reset, start, done_in, clear_overrun, sdi;
  logic         sck, ce, sample_valid, busy, overrun;
  logic [W-1:0] sample_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] resp_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] resp_word = '0;
  int           resp_idx  = 0;

  int   n_valid = 0, n_frames = 0, sck_rises = 0;
  int   ce_rise_cyc = 0, ce_fall_cyc = -1000, ce_low_busy = 0;
  logic ce_p = 1'b0, sck_p = 1'b0, valid_p = 1'b0, busy_p = 1'b0;

  spi_sample_reader #(.WIDTH(W), .CLK_DIV(DIV), .CE_SETUP(GAP), .AUTO(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .done_in       (done_in),
    .clear_overrun (clear_overrun),
    .sdi           (sdi),
    .sck           (sck),
    .ce            (ce),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: loads a word when ce rises, presents the MSB, shifts on each falling sck.
  always @(posedge ce) begin
    resp_word = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
    exp_q.push_back(resp_word);
    resp_idx = 0;
    sdi = resp_word[W-1];
  end

  always @(negedge sck) begin
    if (ce) begin
      resp_idx++;
      sdi = (resp_idx < W) ? resp_word[W-1-resp_idx] : 1'b0;
    end
  end

  // Monitor: frame bookkeeping and scoreboard compare on every valid pulse.
  always @(negedge clk) begin
    if (ce && !ce_p) begin
      n_frames++;
      check("ce_gap", 32'(cyc - ce_fall_cyc >= GAP), 32'd1);
      ce_rise_cyc = cyc;
      sck_rises = 0;
    end
    if (!ce && ce_p) ce_fall_cyc = cyc;
    if (ce && sck && !sck_p) sck_rises++;
    if (busy_p && !busy && !reset) check("ce_low_before_idle", ce_low_busy, GAP);
    if (busy && !ce) ce_low_busy++;
    else             ce_low_busy = 0;
    if (sample_valid) begin
      n_valid++;
      check("valid_width", 32'(valid_p), 32'd0);
      check("exp_depth", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) check("sample_out", sample_out, exp_q.pop_front());
      check("valid_latency", cyc - ce_rise_cyc, FRAME_LAT);
      check("sck_rises", sck_rises, W);
    end
    ce_p = ce; sck_p = sck; valid_p = sample_valid; busy_p = busy;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 1000);
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input logic [W-1:0] word);
    resp_q.push_back(word);
    pulse_start();
    wait_idle("frame_idle");
    check("sample_held", sample_out, word);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int t0;
    int k;
    reset = 1'b1; start = 1'b0; done_in = 1'b0; clear_overrun = 1'b0; sdi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sample", sample_out, 32'h0);
    #1 reset = 1'b0;

    // Basic frame.
    run_frame(32'hDEADBEEF);
    check("t1_no_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of a frame.
    base = n_valid;
    resp_q.push_back($urandom);
    pulse_start();
    k = 0;
    while (sck_rises < 10 && k < 500) begin @(posedge clk); k++; end
    check("t2_reached_edge10", 32'(sck_rises >= 10), 32'd1);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    check("t2_async_sck", 32'(sck), 32'd0);
    check("t2_async_ce", 32'(ce), 32'd0);
    check("t2_async_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    check("t2_no_valid", n_valid, base);
    check("t2_sample_cleared", sample_out, 32'h0);
    run_frame(32'h00000001);

    // Trigger while busy: overrun set, frame unaffected, nothing queued; set beats clear.
    base = n_frames;
    resp_q.push_back(32'h13579BDF);
    pulse_start();
    repeat (40) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t3_overrun_set", 32'(overrun), 32'd1);
    repeat (10) @(posedge clk);
    #1 begin start = 1'b1; clear_overrun = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; clear_overrun = 1'b0; end
    @(negedge clk);
    check("t3_set_wins", 32'(overrun), 32'd1);
    wait_idle("t3_idle");
    repeat (20) @(posedge clk);
    check("t3_single_frame", n_frames, base + 1);
    check("t3_result", sample_out, 32'h13579BDF);
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    @(negedge clk);
    check("t3_cleared", 32'(overrun), 32'd0);

    // start held high: back-to-back frames.
    base = n_valid;
    resp_q.push_back(32'hFFFFFFFF);
    resp_q.push_back(32'h00000000);
    resp_q.push_back(32'hA5A5A5A5);
    @(posedge clk); #1 start = 1'b1;
    k = 0;
    while (n_valid < base + 3 && k < 2000) begin @(posedge clk); k++; end
    #1 start = 1'b0;
    check("t4_overrun", 32'(overrun), 32'd1);
    wait_idle("t4_idle");
    repeat (5) @(posedge clk);
    check("t4_three_valid", n_valid, base + 3);
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;

    // AUTO trigger from an asynchronous done_in edge, then a glitch while busy.
    base = n_frames;
    resp_q.push_back(32'h0F1E2D3C);
    @(posedge clk); #($urandom_range(1, 9)) done_in = 1'b1;
    t0 = cyc;
    k = 0;
    while (!ce && k < 20) begin @(negedge clk); k++; end
    check("t5_auto_latency", 32'((cyc - t0) >= 3 && (cyc - t0) <= 4), 32'd1);
    check("t5_no_overrun_yet", 32'(overrun), 32'd0);
    repeat (10) @(posedge clk);
    #3 done_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 done_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_glitch_overrun", 32'(overrun), 32'd1);
    wait_idle("t5_idle");
    done_in = 1'b0;
    repeat (10) @(posedge clk);
    check("t5_single_frame", n_frames, base + 1);
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;

    // Both end bits set.
    run_frame(32'h80000001);

    // Random words with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run_frame($urandom);
    end

    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_no_overrun", 32'(overrun), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
